// File: rtl/spi_transceiver.sv
// Byte-wide SPI master front end: handshake, CS framing, shift registers and
// control of an external SCLK divider. All four CPOL/CPHA modes are supported.
module spi_transceiver #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_cpol,
  input  logic       i_cpha,
  input  logic       i_hold_cs,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_div_start_n,
  input  logic       i_div_ready,
  input  logic       i_div_sclk,
  input  logic       i_div_lead,
  input  logic       i_div_trail,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  input  logic       i_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, START, SHIFT, HOLD} state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] tx_sr_reg;
  logic [7:0] rx_sr_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       mosi_reg;
  logic       cpol_reg;
  logic       cpha_reg;
  logic       hold_reg;

  logic accept;
  logic sample_stb;
  logic drive_stb;
  logic bits_done;

  assign accept    = i_tx_valid && (state_reg == IDLE);
  assign bits_done = (bit_cnt_reg == 4'd8);

  // Strobes only matter while shifting; the saturated counter also blocks the 8th CPHA=0 trail.
  assign sample_stb = (state_reg == SHIFT) && !bits_done && (cpha_reg ? i_div_trail : i_div_lead);
  assign drive_stb  = (state_reg == SHIFT) && !bits_done && (cpha_reg ? i_div_lead : i_div_trail);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (cnt_reg == SETUP_LAST) state_next = START;
      START:   if (i_div_ready) state_next = SHIFT;
      SHIFT:   if (bits_done && i_div_ready) state_next = HOLD;
      HOLD:    if (cnt_reg == HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_tx_ready    = (state_reg == IDLE);
    o_div_start_n = !((state_reg == START) && i_div_ready);
    o_cs_n        = (state_reg == IDLE) ? !hold_reg : 1'b0;
    o_mosi        = mosi_reg && !o_cs_n;
    o_sclk        = i_div_sclk ^ cpol_reg;
    o_rx_data     = rx_data_reg;
    o_rx_valid    = rx_valid_reg;
  end

  // Phase counter for SETUP/HOLD restarts on every state change.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg <= 8'd0;
    end else if (state_next != state_reg) begin
      cnt_reg <= 8'd0;
    end else if ((state_reg == SETUP) || (state_reg == HOLD)) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bit_cnt_reg  <= 4'd0;
      tx_sr_reg    <= 8'd0;
      rx_sr_reg    <= 8'd0;
      rx_data_reg  <= 8'd0;
      rx_valid_reg <= 1'b0;
      mosi_reg     <= 1'b0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      hold_reg     <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (accept) begin
        cpol_reg    <= i_cpol;
        cpha_reg    <= i_cpha;
        hold_reg    <= i_hold_cs;
        bit_cnt_reg <= 4'd0;
        // CPHA=0 presents bit7 before the first edge; CPHA=1 waits for the first lead.
        if (i_cpha) begin
          tx_sr_reg <= i_tx_data;
          mosi_reg  <= 1'b0;
        end else begin
          tx_sr_reg <= {i_tx_data[6:0], 1'b0};
          mosi_reg  <= i_tx_data[7];
        end
      end else begin
        if (drive_stb) begin
          mosi_reg  <= tx_sr_reg[7];
          tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
        end
        if (sample_stb) begin
          rx_sr_reg   <= {rx_sr_reg[6:0], i_miso};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
        if ((state_reg == SHIFT) && (state_next == HOLD)) begin
          rx_data_reg  <= rx_sr_reg;
          rx_valid_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_transceiver.sv
// Scoreboard bench for spi_transceiver with a behavioural SCLK divider and
// an optional CPHA=1 slave that shifts out a chosen byte.
module tb_spi_transceiver;

  localparam int CS_SETUP = 3;
  localparam int CS_HOLD  = 4;
  localparam int HP       = 2;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic       hold;
    logic       skip_setup;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       hold_cs = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       div_start_n;
  logic       div_ready = 1'b1;
  logic       div_sclk = 1'b0;
  logic       div_lead;
  logic       div_trail;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;

  logic m_lead = 1'b0, m_trail = 1'b0, force_lead = 1'b0, force_trail = 1'b0;
  logic ready_block = 1'b0;
  int   dtick = -1;

  logic       use_slave = 1'b0;
  logic [7:0] slave_byte = 8'd0;
  logic       slave_bit = 1'b0;
  int         slave_idx = 0;

  int tests_run = 0, tests_failed = 0;
  int rx_cnt = 0, exp_rx_total = 0;
  exp_t sb_q[$];
  exp_t cur_exp;
  logic cur_cpha = 1'b0;
  logic [7:0] mon_mosi = 8'd0;
  int mon_n = 0, since = 0, start_cnt = 0, start_since = 0, h = 0;
  logic cs_bad = 1'b0, mosi_bad = 1'b0, meas = 1'b0;

  assign div_lead  = m_lead | force_lead;
  assign div_trail = m_trail | force_trail;
  assign miso      = use_slave ? slave_bit : mosi;

  always #5 clk = ~clk;

  spi_transceiver #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .i_cpol(cpol), .i_cpha(cpha), .i_hold_cs(hold_cs),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_div_start_n(div_start_n),
    .i_div_ready(div_ready), .i_div_sclk(div_sclk), .i_div_lead(div_lead),
    .i_div_trail(div_trail), .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .i_miso(miso)
  );

  // Divider: eight SCLK periods of 2*HP cycles, lead strobe on rise, trail on fall.
  always @(posedge clk) begin
    m_lead  <= 1'b0;
    m_trail <= 1'b0;
    if (dtick < 0) begin
      div_ready <= !ready_block;
      if (!div_start_n && div_ready) begin
        dtick     <= 0;
        div_ready <= 1'b0;
      end
    end else if (dtick < 16 * HP) begin
      if (dtick % HP == 0) begin
        if ((dtick / HP) % 2 == 0) begin
          div_sclk <= 1'b1;
          m_lead   <= 1'b1;
        end else begin
          div_sclk <= 1'b0;
          m_trail  <= 1'b1;
        end
      end
      dtick <= dtick + 1;
    end else begin
      dtick     <= -1;
      div_ready <= !ready_block;
    end
  end

  // CPHA=1 slave: changes MISO on each lead strobe.
  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      slave_idx <= 0;
    end else if (m_lead && slave_idx < 8) begin
      slave_bit <= slave_byte[7 - slave_idx];
      slave_idx <= slave_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: per-transaction capture, CS framing timing, scoreboard pop on rx_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        since = 0; start_cnt = 0; mon_n = 0; mon_mosi = 8'd0; cs_bad = 1'b0;
      end else begin
        since++;
      end
      if (!div_start_n) begin
        start_cnt++;
        if (start_cnt == 1) start_since = since;
      end
      if (!tx_ready && cs_n) cs_bad = 1'b1;
      if (cs_n && mosi) mosi_bad = 1'b1;
      if ((cur_cpha ? div_trail : div_lead) && !cs_n && mon_n < 8) begin
        mon_mosi = {mon_mosi[6:0], mosi};
        mon_n++;
      end
      if (meas) begin
        if (tx_ready) begin
          check("hold_len", h, CS_HOLD);
          check("cs_idle", cs_n, !cur_exp.hold);
          meas = 1'b0;
        end else begin
          h++;
        end
      end
      if (rx_valid) begin
        if (sb_q.size() == 0) begin
          check("rx_unexp", 1, 0);
        end else begin
          cur_exp = sb_q.pop_front();
          $display("[TB] byte tx 0x%02h rx 0x%02h expected 0x%02h", cur_exp.tx, rx_data, cur_exp.rx);
          check("rx_data", rx_data, cur_exp.rx);
          check("mosi_bits", mon_mosi, cur_exp.tx);
          check("nbits", mon_n, 8);
          check("start_pulses", start_cnt, 1);
          check("cs_low", cs_bad, 0);
          if (!cur_exp.skip_setup) check("setup_len", start_since, CS_SETUP + 1);
          meas = 1'b1;
          h = 1;
        end
        rx_cnt++;
      end
    end
  end

  task automatic start_tx(input logic [7:0] d, input logic pol, input logic pha, input logic hold,
                          input logic slave, input logic [7:0] sbyte, input logic skip, input logic push);
    exp_t e;
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!tx_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (!tx_ready) check("to_ready", tx_ready, 1);
    use_slave = slave; slave_byte = sbyte; cur_cpha = pha;
    tx_data = d; cpol = pol; cpha = pha; hold_cs = hold; tx_valid = 1'b1;
    if (push) begin
      e.rx = slave ? sbyte : d; e.tx = d; e.hold = hold; e.skip_setup = skip;
      sb_q.push_back(e);
      exp_rx_total++;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_div_idle();
    int n;
    n = 0;
    while ((!tx_ready || dtick >= 0) && n < 500) begin @(posedge clk); #1; n++; end
    if (dtick >= 0 || !tx_ready) check("to_idle", 0, 1);
  endtask

  task automatic finish_tx(input logic pol);
    int n;
    n = 0;
    while (rx_cnt != exp_rx_total && n < 2000) begin @(posedge clk); #1; n++; end
    check("to_rx", rx_cnt, exp_rx_total);
    wait_div_idle();
    @(negedge clk);
    check("sclk_idle", sclk, pol);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic rp, rh;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs_n, 1);
    check("rst_start", div_start_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_rxd", rx_data, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_sclk", sclk, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // mode 0 loopback, then mode 3 against the slave
    start_tx(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); finish_tx(1'b0);
    start_tx(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1); finish_tx(1'b1);

    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rh = 1'(i % 2);
      start_tx(rd, rp, rh, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); finish_tx(rp);
    end

    // CS held across two bytes
    start_tx(8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1); finish_tx(1'b0);
    check("cs_between", cs_n, 0);
    start_tx(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); finish_tx(1'b0);

    // divider not ready while in START
    ready_block = 1'b1;
    repeat (2) @(posedge clk);
    start_tx(8'h69, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (10 + CS_SETUP) @(posedge clk);
    #1;
    check("start_wait_n", div_start_n, 1);
    check("start_wait_cnt", start_cnt, 0);
    check("start_wait_busy", tx_ready, 0);
    ready_block = 1'b0;
    finish_tx(1'b1);

    // tx_valid during SHIFT, then spurious strobes in IDLE
    start_tx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n = 0;
    while (mon_n < 3 && n < 500) begin @(posedge clk); #1; n++; end
    tx_data = 8'hFF; tx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tx_valid = 1'b0;
    finish_tx(1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      force_lead = 1'b1; @(posedge clk); #1;
      force_lead = 1'b0; force_trail = 1'b1; @(posedge clk); #1;
      force_trail = 1'b0; @(posedge clk); #1;
    end
    @(negedge clk);
    check("spur_cs", cs_n, 1);
    check("spur_ready", tx_ready, 1);
    check("spur_mosi", mosi, 0);
    check("spur_norx", rx_cnt, exp_rx_total);
    start_tx(8'hC6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); finish_tx(1'b0);

    // reset after four bits
    start_tx(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (mon_n < 4 && n < 500) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_cs", cs_n, 1);
    check("mrst_ready", tx_ready, 1);
    check("mrst_rxv", rx_valid, 0);
    check("mrst_rxd", rx_data, 0);
    check("mrst_sclk", sclk, div_sclk);
    repeat (100) @(posedge clk);
    #1;
    check("mrst_norx", rx_cnt, exp_rx_total);
    wait_div_idle();
    start_tx(8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); finish_tx(1'b0);

    check("mosi_gate", mosi_bad, 0);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
